wb_select_pipe: RTL and testbench
=================================

// Module: wb_select_pipe
// PURPOSE
//  Registered, parametrised writeback-select stage for the pipelined MIPS datapath.
//  Per transaction: picks write data from NSRC sources (alu_out, dm_out, pclink, ...) and
//  the destination register (rt / rd / LINK_REG); suppresses writes to $0.
//  Delivers the result through a 2-entry valid/ready skid buffer toward the register file.
//  Also exposes the head entry as a forwarding tap for the hazard unit.
// PARAMETERS
//  DATA_W    32  width of each data source and of out_wdata
//  NSRC      4   number of write-data sources; NSRC >= 2
//  SEL_W     2   width of in_wd_sel; SEL_W = clog2(NSRC), minimum 1
//  REG_AW    5   register-address width
//  LINK_REG  31  destination index used when in_regdst = 2'b10
// PORTS
//  clk          in   1             rising-edge clock
//  rst_n        in   1             reset, synchronous, active-low
//  flush        in   1             drop every buffered entry
//  in_valid     in   1             upstream entry valid
//  in_ready     out  1             stage can accept an entry
//  in_src_data  in   NSRC*DATA_W   source k occupies bits [k*DATA_W +: DATA_W]
//  in_wd_sel    in   SEL_W         write-data source index
//  in_rt        in   REG_AW        rt field
//  in_rd        in   REG_AW        rd field
//  in_regdst    in   2             00=rt, 01=rd, 10=LINK_REG, 11=illegal
//  in_regwrite  in   1             instruction writes the register file
//  out_valid    out  1             head entry valid
//  out_ready    in   1             downstream accepts the head entry
//  out_we       out  1             register-file write enable of the head entry
//  out_waddr    out  REG_AW        destination register of the head entry
//  out_wdata    out  DATA_W        write data of the head entry
//  fwd_valid    out  1             out_valid & out_we; forwarding tap is usable
//  err          out  1             sticky flag: illegal select was accepted
// BEHAVIOUR
//  Clock and reset
//  - One clock; reset is synchronous and active-low.
//  - rst_n=0 at a clk edge: buffer EMPTY, err=0.
//  - Every output register (out_*, fwd_valid) resets to 0; in_ready=1 after reset.
//  Entry decode, applied at acceptance
//  - wdata = in_src_data[in_wd_sel] when in_wd_sel < NSRC.
//  - waddr selected by in_regdst; we = in_regwrite & (waddr != 0).
//  - Illegal select (in_wd_sel >= NSRC or in_regdst = 11) stores we=0, wdata=0, waddr=0
//    and sets err; err clears only on reset.
//  Handshake
//  - Push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready is registered: 1 iff occupancy < 2 after the current edge's update.
//  - in_ready does not depend combinationally on out_ready.
//  - Outputs always show the head entry, fed directly from registers.
//  - Held stable while out_valid=1 and out_ready=0.
//  State machine (occupancy)
//  - EMPTY: push -> ONE.
//  - ONE: push&pop -> ONE (new entry becomes head, latency 1 cycle);
//         push only -> TWO; pop only -> EMPTY.
//  - TWO: in_ready=0 so no push; pop -> ONE (skid entry promoted next cycle).
//  - Minimum latency: in_valid accepted at edge N -> out_valid=1 after edge N.
//  - Throughput 1 entry/cycle while out_ready=1.
//  - Entry order is strictly FIFO.
//  Boundaries
//  - flush=1 at an edge: -> EMPTY and in_ready=1, regardless of push/pop that cycle.
//  - A push in the flush cycle is discarded; err is not cleared.
//  - rst_n=0 has priority over flush.
//  - Reset mid-transfer discards all entries; no partial state survives.
//  - pop while EMPTY is impossible because out_valid=0.
// TESTING
//  - Reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, in_ready=1, err=0,
//    out_wdata=0.
//  - Select: srcs {A,B,C,D}={1,2,3,4}, sel=2, regdst=10, regwrite=1, out_ready=1
//    -> next cycle out_wdata=3, out_waddr=31, out_we=1, fwd_valid=1.
//  - $0 suppression: regdst=00, rt=0, regwrite=1 -> out_we=0, fwd_valid=0, out_valid=1.
//  - Backpressure: out_ready=0, push 3 entries -> accepts 2, in_ready=0 on third.
//    Then out_ready=1 -> entries drain in order over 2 cycles; in_ready=1 one cycle
//    after first pop.
//  - Flush: occupancy TWO, assert flush with in_valid=1 -> next cycle out_valid=0,
//    in_ready=1, pushed entry lost.
//  - Illegal: NSRC=3, sel=3 -> out_we=0, out_wdata=0, err=1 and remains 1 until reset.

Source files
------------

// File: rtl/wb_select_pipe_if.sv
// Writeback-select bus: upstream entry fields, downstream register-file
// write port, forwarding tap and sticky error flag.
interface wb_select_pipe_if #(
  parameter int DATA_W = 32,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2,
  parameter int REG_AW = 5
);
  // Upstream side
  logic                   in_valid;
  logic                   in_ready;
  logic [NSRC*DATA_W-1:0] in_src_data;
  logic [SEL_W-1:0]       in_wd_sel;
  logic [REG_AW-1:0]      in_rt;
  logic [REG_AW-1:0]      in_rd;
  logic [1:0]             in_regdst;
  logic                   in_regwrite;

  // Downstream side
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_we;
  logic [REG_AW-1:0]      out_waddr;
  logic [DATA_W-1:0]      out_wdata;

  // Hazard-unit tap and status
  logic                   fwd_valid;
  logic                   err;

  // Producer of entries / consumer of results (pipeline control, bench)
  modport master (
    output in_valid, in_src_data, in_wd_sel, in_rt, in_rd, in_regdst, in_regwrite,
    output out_ready,
    input  in_ready, out_valid, out_we, out_waddr, out_wdata, fwd_valid, err
  );

  // The writeback-select stage itself
  modport slave (
    input  in_valid, in_src_data, in_wd_sel, in_rt, in_rd, in_regdst, in_regwrite,
    input  out_ready,
    output in_ready, out_valid, out_we, out_waddr, out_wdata, fwd_valid, err
  );
endinterface

// File: rtl/wb_select_pipe.sv
// Writeback-select stage: decodes write data / destination register for each
// accepted entry and hands it to the register file through a 2-entry skid
// buffer. The head entry doubles as a forwarding tap for the hazard unit.
module wb_select_pipe #(
  parameter int DATA_W   = 32,
  parameter int NSRC     = 4,
  parameter int SEL_W    = 2,
  parameter int REG_AW   = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  wb_select_pipe_if.slave   bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  // True when the select index names an existing source.
  function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(sel) == k) hit = 1'b1;
    end
    return hit;
  endfunction

  // Illegal entries are stored as a harmless no-write with zeroed fields.
  function automatic logic is_illegal(input logic [SEL_W-1:0] sel,
                                      input logic [1:0]       regdst);
    return !sel_in_range(sel) || (regdst == 2'b11);
  endfunction

  // Full entry decode: data mux, destination mux and $0 write suppression.
  function automatic entry_t decode_entry(
    input logic [NSRC*DATA_W-1:0] src,
    input logic [SEL_W-1:0]       sel,
    input logic [REG_AW-1:0]      rt,
    input logic [REG_AW-1:0]      rd,
    input logic [1:0]             regdst,
    input logic                   regwrite
  );
    entry_t            e;
    logic [DATA_W-1:0] data;
    logic [REG_AW-1:0] addr;
    data = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(sel) == k) data = src[k*DATA_W +: DATA_W];
    end
    case (regdst)
      2'b00:   addr = rt;
      2'b01:   addr = rd;
      default: addr = REG_AW'(LINK_REG);
    endcase
    e = '0;
    if (!is_illegal(sel, regdst)) begin
      e.wdata = data;
      e.waddr = addr;
      e.we    = regwrite && (addr != '0);
    end
    return e;
  endfunction

  // ---- stage p0: combinational decode of the offered entry ----
  entry_t w_entry_p0;
  logic   w_illegal_p0;
  logic   w_push;
  logic   w_pop;

  // ---- stage p1: head (visible) and skid registers ----
  occ_t   r_state;
  logic   r_in_ready;
  logic   r_vld_p1;
  logic   r_fwd_p1;
  entry_t r_head_p1;
  entry_t r_skid_p1;
  logic   r_err;

  assign w_entry_p0   = decode_entry(bus.in_src_data, bus.in_wd_sel, bus.in_rt,
                                     bus.in_rd, bus.in_regdst, bus.in_regwrite);
  assign w_illegal_p0 = is_illegal(bus.in_wd_sel, bus.in_regdst);
  assign w_push       = bus.in_valid && r_in_ready;
  assign w_pop        = r_vld_p1 && bus.out_ready;

  // Occupancy FSM owning the head/skid registers and every registered output;
  // in_ready is precomputed here so it never depends on out_ready in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_vld_p1   <= 1'b0;
      r_fwd_p1   <= 1'b0;
      r_head_p1  <= '0;
      r_skid_p1  <= '0;
      r_err      <= 1'b0;
    end else if (flush) begin
      // Everything buffered and anything offered this cycle is dropped; err is kept.
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_vld_p1   <= 1'b0;
      r_fwd_p1   <= 1'b0;
    end else begin
      if (w_push && w_illegal_p0) r_err <= 1'b1;
      case (r_state)
        S_EMPTY: begin
          if (w_push) begin
            r_head_p1 <= w_entry_p0;
            r_vld_p1  <= 1'b1;
            r_fwd_p1  <= w_entry_p0.we;
            r_state   <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_push && w_pop) begin
            // Streaming: the new entry replaces the departing head directly.
            r_head_p1 <= w_entry_p0;
            r_fwd_p1  <= w_entry_p0.we;
          end else if (w_push) begin
            r_skid_p1  <= w_entry_p0;
            r_in_ready <= 1'b0;
            r_state    <= S_TWO;
          end else if (w_pop) begin
            r_vld_p1 <= 1'b0;
            r_fwd_p1 <= 1'b0;
            r_state  <= S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (w_pop) begin
            r_head_p1  <= r_skid_p1;
            r_fwd_p1   <= r_skid_p1.we;
            r_in_ready <= 1'b1;
            r_state    <= S_ONE;
          end
        end
        default: begin
          r_state    <= S_EMPTY;
          r_in_ready <= 1'b1;
          r_vld_p1   <= 1'b0;
          r_fwd_p1   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_vld_p1;
  assign bus.out_we    = r_head_p1.we;
  assign bus.out_waddr = r_head_p1.waddr;
  assign bus.out_wdata = r_head_p1.wdata;
  assign bus.fwd_valid = r_fwd_p1;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_wb_select_pipe.sv
// Scoreboard bench for wb_select_pipe: a driver pushes reference entries into
// a queue when the stage accepts them; a negedge monitor compares the head.
module tb_wb_select_pipe;
  localparam int DATA_W = 32;
  localparam int NSRC   = 4;
  localparam int SEL_W  = 2;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              we;
    logic [REG_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  always #5 clk = ~clk;

  wb_select_pipe_if #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .REG_AW(REG_AW)) bus ();
  wb_select_pipe_if #(.DATA_W(DATA_W), .NSRC(3), .SEL_W(2), .REG_AW(REG_AW)) bus3 ();

  wb_select_pipe #(.DATA_W(DATA_W), .NSRC(NSRC), .SEL_W(SEL_W), .REG_AW(REG_AW), .LINK_REG(31))
    dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus.slave));

  wb_select_pipe #(.DATA_W(DATA_W), .NSRC(3), .SEL_W(2), .REG_AW(REG_AW), .LINK_REG(31))
    dut3 (.clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(bus3.slave));

  logic [DATA_W-1:0] src [NSRC];
  assign bus.in_src_data = {src[3], src[2], src[1], src[0]};

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exq[$];
  exp_t hd;
  int   occ   = 0;
  logic err_m = 1'b0;
  logic rst_q = 1'b0, flush_q = 1'b0, push_q = 1'b0, pop_q = 1'b0, ill_q = 1'b0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: what the register file should see for one instruction.
  function automatic exp_t model_entry(int nsrc, int sel, logic [REG_AW-1:0] rt,
                                       logic [REG_AW-1:0] rd, logic [1:0] regdst,
                                       logic regwrite, logic [DATA_W-1:0] data);
    exp_t e;
    int   addr;
    e = '0;
    if (sel >= nsrc || regdst == 2'b11) return e;
    if (regdst == 2'b00)      addr = int'(rt);
    else if (regdst == 2'b01) addr = int'(rd);
    else                      addr = 31;
    e.waddr = REG_AW'(addr);
    e.wdata = data;
    e.we    = regwrite && (addr != 0);
    return e;
  endfunction

  // Decide whether the values now on the inputs will be accepted at the next edge.
  task automatic commit();
    exp_t e;
    rst_q   = !rst_n;
    flush_q = flush;
    push_q  = rst_n && !flush && bus.in_valid && (bus.in_ready === 1'b1);
    ill_q   = (int'(bus.in_wd_sel) >= NSRC) || (bus.in_regdst == 2'b11);
    if (push_q) begin
      e = model_entry(NSRC, int'(bus.in_wd_sel), bus.in_rt, bus.in_rd,
                      bus.in_regdst, bus.in_regwrite, src[bus.in_wd_sel]);
      exq.push_back(e);
    end
  endtask

  // Advance one edge and check occupancy-derived handshake and sticky error.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst_q) begin
      occ   = 0;
      err_m = 1'b0;
    end else if (flush_q) begin
      occ = 0;
    end else begin
      occ = occ + (push_q ? 1 : 0) - (pop_q ? 1 : 0);
      if (push_q && ill_q) err_m = 1'b1;
    end
    chk("in_ready",  64'(bus.in_ready),  64'(occ < 2));
    chk("out_valid", 64'(bus.out_valid), 64'(occ > 0));
    chk("err",       64'(bus.err),       64'(err_m));
  endtask

  task automatic cyc();
    commit();
    tick();
  endtask

  task automatic set_in(logic v, logic [SEL_W-1:0] sel, logic [1:0] regdst,
                        logic [REG_AW-1:0] rt, logic [REG_AW-1:0] rd, logic rw);
    bus.in_valid    = v;
    bus.in_wd_sel   = sel;
    bus.in_regdst   = regdst;
    bus.in_rt       = rt;
    bus.in_rd       = rd;
    bus.in_regwrite = rw;
  endtask

  // Monitor: compare the presented head with the oldest expected entry.
  always @(negedge clk) begin
    pop_q = 1'b0;
    if (!rst_n || flush) begin
      exq.delete();
    end else if (bus.out_valid === 1'b1) begin
      if (exq.size() == 0) begin
        chk("out_valid_without_expected", 64'(bus.out_valid), 64'd0);
      end else begin
        hd = exq[0];
        chk("head_entry", 64'({bus.out_we, bus.out_waddr, bus.out_wdata}), 64'(hd));
        chk("fwd_valid",  64'(bus.fwd_valid), 64'(hd.we));
        if (bus.out_ready === 1'b1) begin
          void'(exq.pop_front());
          pop_q = 1'b1;
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < NSRC; k++) src[k] = '0;
    set_in(1'b0, '0, 2'b00, '0, '0, 1'b0);
    bus.out_ready    = 1'b1;
    bus3.in_valid    = 1'b0;
    bus3.in_src_data = {32'd9, 32'd8, 32'd7};
    bus3.in_wd_sel   = 2'd0;
    bus3.in_rt       = 5'd0;
    bus3.in_rd       = 5'd0;
    bus3.in_regdst   = 2'b00;
    bus3.in_regwrite = 1'b0;
    bus3.out_ready   = 1'b1;

    // Reset held two cycles with a valid entry offered
    rst_n = 1'b0;
    set_in(1'b1, 2'd1, 2'b00, 5'd3, 5'd4, 1'b1);
    cyc();
    cyc();
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_err",       64'(bus.err),       64'd0);
    chk("rst_out_wdata", 64'(bus.out_wdata), 64'd0);
    chk("rst_fwd_valid", 64'(bus.fwd_valid), 64'd0);
    rst_n = 1'b1;
    set_in(1'b0, '0, 2'b00, '0, '0, 1'b0);
    cyc();

    // Source select with link destination
    src[0] = 32'd1; src[1] = 32'd2; src[2] = 32'd3; src[3] = 32'd4;
    bus.out_ready = 1'b1;
    set_in(1'b1, 2'd2, 2'b10, 5'd7, 5'd8, 1'b1);
    cyc();
    chk("sel_wdata", 64'(bus.out_wdata), 64'd3);
    chk("sel_waddr", 64'(bus.out_waddr), 64'd31);
    chk("sel_we",    64'(bus.out_we),    64'd1);
    chk("sel_fwd",   64'(bus.fwd_valid), 64'd1);
    set_in(1'b0, '0, 2'b00, '0, '0, 1'b0);
    cyc();

    // Write to $0 suppressed
    bus.out_ready = 1'b0;
    set_in(1'b1, 2'd0, 2'b00, 5'd0, 5'd9, 1'b1);
    cyc();
    chk("zero_we",    64'(bus.out_we),    64'd0);
    chk("zero_fwd",   64'(bus.fwd_valid), 64'd0);
    chk("zero_valid", 64'(bus.out_valid), 64'd1);
    bus.out_ready = 1'b1;
    set_in(1'b0, '0, 2'b00, '0, '0, 1'b0);
    cyc();

    // Backpressure: three offered, two accepted, drained in order
    src[0] = 32'd10; src[1] = 32'd20; src[2] = 32'd30; src[3] = 32'd40;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, SEL_W'(i), 2'b01, 5'd1, 5'(i + 5), 1'b1);
      cyc();
    end
    chk("bp_in_ready_full", 64'(bus.in_ready),  64'd0);
    chk("bp_head_first",    64'(bus.out_wdata), 64'd10);
    set_in(1'b0, '0, 2'b00, '0, '0, 1'b0);
    bus.out_ready = 1'b1;
    cyc();
    chk("bp_head_second",    64'(bus.out_wdata), 64'd20);
    chk("bp_in_ready_after", 64'(bus.in_ready),  64'd1);
    cyc();
    chk("bp_drained", 64'(bus.out_valid), 64'd0);

    // Flush while full, with a push offered in the flush cycle
    bus.out_ready = 1'b0;
    set_in(1'b1, 2'd3, 2'b00, 5'd2, 5'd0, 1'b1);
    cyc();
    cyc();
    flush = 1'b1;
    set_in(1'b1, 2'd1, 2'b01, 5'd0, 5'd6, 1'b1);
    cyc();
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready",  64'(bus.in_ready),  64'd1);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b0, '0, 2'b00, '0, '0, 1'b0);
    cyc();
    chk("flush_entry_lost", 64'(bus.out_valid), 64'd0);

    // Illegal destination on the main instance
    bus.out_ready = 1'b0;
    set_in(1'b1, 2'd1, 2'b11, 5'd4, 5'd5, 1'b1);
    cyc();
    chk("ill_err",   64'(bus.err),       64'd1);
    chk("ill_we",    64'(bus.out_we),    64'd0);
    chk("ill_wdata", 64'(bus.out_wdata), 64'd0);
    bus.out_ready = 1'b1;
    set_in(1'b0, '0, 2'b00, '0, '0, 1'b0);
    cyc();
    cyc();
    chk("ill_err_sticky", 64'(bus.err), 64'd1);

    // Illegal source index on a 3-source instance
    bus3.in_valid    = 1'b1;
    bus3.in_wd_sel   = 2'd3;
    bus3.in_regdst   = 2'b00;
    bus3.in_rt       = 5'd5;
    bus3.in_regwrite = 1'b1;
    bus3.out_ready   = 1'b0;
    cyc();
    chk("n3_valid", 64'(bus3.out_valid), 64'd1);
    chk("n3_we",    64'(bus3.out_we),    64'd0);
    chk("n3_wdata", 64'(bus3.out_wdata), 64'd0);
    chk("n3_err",   64'(bus3.err),       64'd1);
    bus3.out_ready = 1'b1;
    bus3.in_wd_sel = 2'd1;
    cyc();
    chk("n3_legal_wdata", 64'(bus3.out_wdata), 64'd8);
    chk("n3_legal_we",    64'(bus3.out_we),    64'd1);
    bus3.in_valid = 1'b0;
    cyc();
    cyc();
    chk("n3_err_sticky", 64'(bus3.err), 64'd1);
    rst_n = 1'b0;
    cyc();
    chk("n3_err_reset", 64'(bus3.err), 64'd0);
    rst_n = 1'b1;
    cyc();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NSRC; k++) src[k] = $urandom;
      bus.in_valid    = ($urandom_range(0, 9) < 7);
      bus.in_wd_sel   = SEL_W'($urandom_range(0, NSRC - 1));
      bus.in_regdst   = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      bus.in_rt       = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
      bus.in_rd       = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom);
      bus.in_regwrite = 1'($urandom_range(0, 1));
      bus.out_ready   = ($urandom_range(0, 9) < 6);
      flush           = ($urandom_range(0, 39) == 0);
      rst_n           = !($urandom_range(0, 149) == 0);
      cyc();
    end

    // Drain
    rst_n = 1'b1;
    flush = 1'b0;
    bus.out_ready = 1'b1;
    set_in(1'b0, '0, 2'b00, '0, '0, 1'b0);
    repeat (4) cyc();
    chk("drained_queue", 64'(exq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
